// File: rtl/voxel_write_scheduler.sv
// voxel_write_scheduler: queues polar voxel points from the point generator and
// paces single-cycle flush / write strobes into the rotational frame buffer,
// holding the write fields steady while the buffer consumes them.
module voxel_write_scheduler #(
   parameter int ROTATIONAL_RES = 1024,
   parameter int DISPLAY_RADIUS = 32,
   parameter int DISPLAY_HEIGHT = 64,
   parameter int FIFO_DEPTH     = 16
) (
   input  logic                              clk_in,
   input  logic                              rst_in,
   input  logic                              flush_req,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [$clog2(DISPLAY_RADIUS)-1:0] in_radius,
   input  logic [$clog2(ROTATIONAL_RES)-1:0] in_theta,
   input  logic [$clog2(DISPLAY_HEIGHT)-1:0] in_z,
   input  logic                              fb_busy,
   output logic                              fb_flush,
   output logic                              fb_new_data,
   output logic [$clog2(DISPLAY_RADIUS)-1:0] fb_radius,
   output logic [$clog2(ROTATIONAL_RES)-1:0] fb_theta,
   output logic [$clog2(DISPLAY_HEIGHT)-1:0] fb_z,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
   output logic                              idle
);

   localparam int RW = $clog2(DISPLAY_RADIUS);
   localparam int TW = $clog2(ROTATIONAL_RES);
   localparam int ZW = $clog2(DISPLAY_HEIGHT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = RW + TW + ZW;

   typedef enum logic [1:0] {IDLE, STROBE, GUARD, WAIT} state_t;

   state_t        state;
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_idx;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          flush_pending;
   logic          pending_next;
   logic          push;
   logic          dispatch_flush;
   logic          dispatch_write;
   logic          next_is_idle;
   logic [EW-1:0] head;

   assign in_ready       = (count != CW'(FIFO_DEPTH));
   assign fifo_count     = count;
   assign push           = in_valid && in_ready;
   assign dispatch_flush = (state == IDLE) && !fb_busy && flush_pending;
   assign dispatch_write = (state == IDLE) && !fb_busy && !flush_pending && (count != '0);
   assign next_is_idle   = ((state == IDLE) && !dispatch_flush && !dispatch_write) ||
                           ((state == WAIT) && !fb_busy);
   assign head           = mem[rd_ptr];

   // A flush restarts the queue at slot 0, so a point pushed alongside it lands there.
   assign wr_idx = flush_req ? '0 : wr_ptr;

   // A request arriving on the very edge a flush is dispatched is kept pending so
   // it still produces its own flush; otherwise repeated requests merge into one.
   assign pending_next = flush_req || (flush_pending && !dispatch_flush);

   // Queue occupancy after this edge; flush discards everything except a same-cycle push.
   always_comb begin
      count_next = count;
      if (flush_req) begin
         count_next = push ? CW'(1) : '0;
      end else if (push && !dispatch_write) begin
         count_next = count + CW'(1);
      end else if (!push && dispatch_write) begin
         count_next = count - CW'(1);
      end
   end

   // Queue pointers, occupancy and the pending-flush flag.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         flush_pending <= 1'b0;
      end else begin
         count         <= count_next;
         flush_pending <= pending_next;
         if (flush_req) begin
            rd_ptr <= '0;
            wr_ptr <= push ? AW'(1) : '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + AW'(1);
            end
            if (dispatch_write) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
         end
      end
   end

   // Point storage; contents need no reset because occupancy governs validity.
   always_ff @(posedge clk_in) begin
      if (push) begin
         mem[wr_idx] <= {in_radius, in_theta, in_z};
      end
   end

   // Dispatch FSM: one strobe cycle, one guard cycle while the buffer raises busy,
   // then wait for busy to clear before the next dispatch.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state       <= IDLE;
         fb_flush    <= 1'b0;
         fb_new_data <= 1'b0;
         fb_radius   <= '0;
         fb_theta    <= '0;
         fb_z        <= '0;
         idle        <= 1'b0;
      end else begin
         fb_flush    <= 1'b0;
         fb_new_data <= 1'b0;
         idle        <= next_is_idle && (count_next == '0) && !pending_next && !fb_busy;
         case (state)
            IDLE: begin
               if (dispatch_flush) begin
                  fb_flush <= 1'b1;
                  state    <= STROBE;
               end else if (dispatch_write) begin
                  fb_new_data                 <= 1'b1;
                  {fb_radius, fb_theta, fb_z} <= head;
                  state                       <= STROBE;
               end
            end
            STROBE:  state <= GUARD;
            GUARD:   state <= WAIT;
            WAIT: begin
               if (!fb_busy) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/voxel_write_scheduler.md
Name: voxel_write_scheduler

Overview:
- Sits directly upstream of the rotational frame buffer and is its only writer.
- Queues polar voxel points (radius, theta, z) from the point generator in a FIFO.
- Issues one-cycle flush and new_data strobes to the frame buffer, honouring its busy timing; holds address/data fields stable for the whole buffer write.
- Flush requests discard stale queued points and clear the frame before any new point is written.

Parameters:
ROTATIONAL_RES, 1024, angular slots per revolution; theta width = $clog2(ROTATIONAL_RES)
DISPLAY_RADIUS, 32, radial positions; radius width = $clog2(DISPLAY_RADIUS)
DISPLAY_HEIGHT, 64, vertical voxels; z width = $clog2(DISPLAY_HEIGHT)
FIFO_DEPTH, 16, point queue entries; power of two, >= 2

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
flush_req  input  1  one-cycle request: discard queue, clear frame buffer
in_valid  input  1  point valid
in_ready  output  1  point accepted when in_valid && in_ready
in_radius  input  $clog2(DISPLAY_RADIUS)  point radius
in_theta  input  $clog2(ROTATIONAL_RES)  point angle
in_z  input  $clog2(DISPLAY_HEIGHT)  point height
fb_busy  input  1  frame buffer busy
fb_flush  output  1  one-cycle flush strobe to frame buffer
fb_new_data  output  1  one-cycle write strobe to frame buffer
fb_radius  output  $clog2(DISPLAY_RADIUS)  write radius, held
fb_theta  output  $clog2(ROTATIONAL_RES)  write theta, held
fb_z  output  $clog2(DISPLAY_HEIGHT)  write z, held
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries queued
idle  output  1  queue empty, no flush pending, FSM in IDLE, fb_busy low

Behaviour:
- Reset:
  - All outputs 0 except in_ready=1.
  - FIFO emptied; flush_pending cleared; FSM to IDLE.
  - Reset mid-write abandons the write; no further strobes.
- FIFO:
  - in_ready = (fifo_count != FIFO_DEPTH), combinational from count.
  - Push on in_valid && in_ready. Pop only on dispatch.
  - Simultaneous push and pop while full is not possible (in_ready=0); while non-full, count stays unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Flush:
  - flush_req sets flush_pending and resets FIFO pointers and count to 0 on the same edge.
  - A push in the same cycle as flush_req is kept: count=1 after the edge, and the point belongs to the new frame.
  - flush_req during an in-flight write does not abort it; the flush issues after that write completes.
  - Repeated flush_req while pending merges into one flush.
- FSM states: IDLE, STROBE, GUARD, WAIT.
  - IDLE, fb_busy=0, flush_pending=1: register fb_flush=1, clear flush_pending, go to STROBE. Flush has priority over a queued point.
  - IDLE, fb_busy=0, flush_pending=0, FIFO non-empty: pop head; register fb_new_data=1 and fb_radius/fb_theta/fb_z=head; go to STROBE.
  - STROBE: the strobe is visible for exactly this cycle. Clear the strobe and go to GUARD.
  - GUARD: one cycle; fb_busy is ignored because the buffer raises busy the cycle after the strobe. Go to WAIT.
  - WAIT: stay while fb_busy=1; on fb_busy=0 go to IDLE.
- Strobe spacing:
  - Minimum 4 cycles between consecutive strobes: STROBE, GUARD, at least one WAIT cycle, IDLE.
  - fb_flush and fb_new_data are never high together.
- Field hold:
  - fb_radius/fb_theta/fb_z change only on a write dispatch edge. They are held through the buffer's WRITING and WAIT phases because the buffer reads radius/z combinationally late in the write.
  - A flush dispatch leaves the fields unchanged.
- In IDLE with fb_busy=1 (e.g. externally held): no dispatch.
- idle is registered from the state after each edge.

Test Plan:
- Reset, then model a buffer whose busy goes high 1 cycle after a strobe for 4 cycles; push (r=5,θ=700,z=10) -> fb_new_data high exactly 1 cycle with fields 5/700/10; fields held until the next dispatch; idle=1 after busy drops.
- Push 16 points with the buffer stalled busy -> in_ready=0 at count 16; 17th in_valid not accepted; release busy -> 16 writes in FIFO order, each ≥4 cycles apart, count returns to 0.
- Queue 3 points, pulse flush_req while a write is in flight -> count=0 next cycle; current write completes; then one fb_flush; none of the 2 stale points are written.
- flush_req and in_valid (r=1,θ=0,z=63) in the same cycle -> count=1; fb_flush issues first, then fb_new_data with 1/0/63 only after busy falls.
- Assert rst_in during GUARD -> next cycle all strobes 0, count=0, in_ready=1, idle=1 once fb_busy=0; no further strobe without new input.
- Boundary fields θ=1023, θ=511, θ=512, r=31, z=63 -> passed through unaltered.
